// File: rtl/pow2_div_ctrl_pkg.sv
// Shared types and constants for the power-of-two clock divider controller.
package pow2_div_ctrl_pkg;

  localparam int DEF_LOG2_W   = 4;
  localparam int DEF_MAX_LOG2 = 15;
  localparam int TICK_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/pow2_div_counter.sv
// Period counter for pow2_div_ctrl: counts 0 .. 2^cur-1 and wraps.
// Reports the terminal count (hit) and the divided-clock level bit.
module pow2_div_counter
  import pow2_div_ctrl_pkg::*;
#(
  parameter int LOG2_W   = DEF_LOG2_W,
  parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [LOG2_W-1:0] cur,
  output logic              hit,
  output logic              level
);

  localparam int CW = MAX_LOG2 + 1;

  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [CW-1:0]       one_sh, term, half;

  // Terminal/level decode from the held count, and next-count selection.
  always_comb begin
    one_sh = CW'(1) << cur;
    term   = one_sh - CW'(1);
    half   = one_sh >> 1;
    hit    = ({1'b0, cnt_q} == term);
    // Level is the top bit of the period: cnt[cur-1]; with cur=0 it sits high.
    level  = (cur == '0) ? 1'b1 : (({1'b0, cnt_q} & half) != '0);
    cnt_d  = cnt_q;
    if (clr)      cnt_d = '0;
    else if (adv) cnt_d = hit ? '0 : cnt_q + MAX_LOG2'(1);
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pow2_div_ctrl.sv
// Power-of-two clock divider controller: IDLE/RUN/PEND FSM with a
// valid/ready exponent-change handshake. New exponents taken while running
// are held until the end of the current period so the output never glitches.
// Optional macro POW2_DIV_CTRL_TICK_CNT_EN adds a free-running 16-bit
// io_tick_count output cleared only by reset.
module pow2_div_ctrl
  import pow2_div_ctrl_pkg::*;
#(
  parameter int LOG2_W   = DEF_LOG2_W,
  parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_enable,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [LOG2_W-1:0] io_req_log2,
  output logic              io_tick,
  output logic              io_clk_level,
  output logic [LOG2_W-1:0] io_cur_log2,
  output logic              io_busy
`ifdef POW2_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] io_tick_count
`endif
);

  localparam logic [LOG2_W-1:0] MAX_K = LOG2_W'(MAX_LOG2);

  state_e            state_q, state_d;
  logic [LOG2_W-1:0] cur_q, cur_d;
  logic [LOG2_W-1:0] pend_q, pend_d;
  logic              ready_q, ready_d;
  logic [LOG2_W-1:0] req_k;
  logic              acc, clr, adv, hit, lvl, running;

  pow2_div_counter #(
    .LOG2_W  (LOG2_W),
    .MAX_LOG2(MAX_LOG2)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (clr),
    .adv  (adv),
    .cur  (cur_q),
    .hit  (hit),
    .level(lvl)
  );

  // Outputs decode from registered state only.
  assign running      = (state_q != ST_IDLE);
  assign io_tick      = running & hit;
  assign io_clk_level = running & lvl;
  assign io_busy      = (state_q == ST_PEND);
  assign io_req_ready = ready_q;
  assign io_cur_log2  = cur_q;

  // Next-state, exponent update and counter control.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    clr     = 1'b0;
    adv     = 1'b0;
    acc     = io_req_valid & ready_q;
    req_k   = (io_req_log2 > MAX_K) ? MAX_K : io_req_log2;
    case (state_q)
      ST_IDLE: begin
        clr = 1'b1;
        if (acc)       cur_d   = req_k;
        if (io_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!io_enable) begin
          // Stopping: a same-cycle request lands directly in IDLE.
          state_d = ST_IDLE;
          clr     = 1'b1;
          if (acc) cur_d = req_k;
        end else begin
          adv = 1'b1;
          if (acc) begin
            state_d = ST_PEND;
            pend_d  = req_k;
          end
        end
      end
      ST_PEND: begin
        if (!io_enable) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
          cur_d   = pend_q;
          pend_d  = '0;
        end else begin
          adv = 1'b1;
          // Swap ratio only at the period boundary; counter wraps to 0 here.
          if (hit) begin
            state_d = ST_RUN;
            cur_d   = pend_q;
            pend_d  = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_PEND);
  end

  // State registers; ready held low through reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

`ifdef POW2_DIV_CTRL_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tcnt_q, tcnt_d;

  // Tick counter, wraps naturally at 0xFFFF.
  always_comb tcnt_d = io_tick ? tcnt_q + TICK_CNT_W'(1) : tcnt_q;

  // Tick counter register.
  always_ff @(posedge clock) begin
    if (reset) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end

  assign io_tick_count = tcnt_q;
`endif

endmodule

// File: tb/tb_pow2_div_ctrl.sv
// Self-checking bench for pow2_div_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pow2_div_ctrl;

  localparam int LW = 4;
  localparam int ML = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_enable = 1'b0;
  logic          io_req_valid = 1'b0;
  logic [LW-1:0] io_req_log2 = '0;
  logic          io_req_ready, io_tick, io_clk_level, io_busy;
  logic [LW-1:0] io_cur_log2;
`ifdef POW2_DIV_CTRL_TICK_CNT_EN
  logic [15:0]   io_tick_count;
`endif

  pow2_div_ctrl #(.LOG2_W(LW), .MAX_LOG2(ML)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_log2  (io_req_log2),
    .io_tick      (io_tick),
    .io_clk_level (io_clk_level),
    .io_cur_log2  (io_cur_log2),
    .io_busy      (io_busy)
`ifdef POW2_DIV_CTRL_TICK_CNT_EN
    ,
    .io_tick_count(io_tick_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_on = 0, m_run = 0, m_pv = 0, m_rdy_blk = 1;
  int m_cur = 0, m_pend = 0, m_phase = 0, m_tcnt = 0;
  int mk;
  bit macc, mtk;

  function automatic int period(input int c);
    return 1 << c;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_on = 1; m_run = 0; m_pv = 0; m_rdy_blk = 1;
      m_cur = 0; m_pend = 0; m_phase = 0; m_tcnt = 0;
    end else begin
      macc = io_req_valid && !m_pv && !m_rdy_blk;
      mk   = (int'(io_req_log2) > ML) ? ML : int'(io_req_log2);
      mtk  = m_run && (m_phase == period(m_cur) - 1);
      m_rdy_blk = 0;
      if (mtk) m_tcnt = (m_tcnt + 1) & 16'hFFFF;
      if (!m_run) begin
        if (macc) m_cur = mk;
        if (io_enable) begin m_run = 1; m_phase = 0; end
      end else if (!io_enable) begin
        m_run = 0; m_phase = 0;
        if (m_pv) begin m_cur = m_pend; m_pv = 0; end
        else if (macc) m_cur = mk;
      end else begin
        m_phase = mtk ? 0 : m_phase + 1;
        if (m_pv && mtk) begin m_cur = m_pend; m_pv = 0; end
        else if (macc) begin m_pv = 1; m_pend = mk; end
      end
    end
  end

  // Compare DUT against model every cycle, away from the rising edge.
  always @(negedge clock) begin
    if (m_on) begin
      chk("m_tick", 32'(io_tick), 32'(m_run && (m_phase == period(m_cur) - 1)));
      chk("m_level", 32'(io_clk_level),
          32'(m_run && (m_cur == 0 || m_phase >= period(m_cur) / 2)));
      chk("m_cur", 32'(io_cur_log2), 32'(m_cur));
      chk("m_busy", 32'(io_busy), 32'(m_pv));
      chk("m_ready", 32'(io_req_ready), 32'(!m_pv && !m_rdy_blk));
`ifdef POW2_DIV_CTRL_TICK_CNT_EN
      chk("m_tcnt", 32'(io_tick_count), 32'(m_tcnt));
`endif
    end
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int ticks, last;
    // Reset state
    step(); step();
    chk("rst_ready", 32'(io_req_ready), 0);
    chk("rst_cur", 32'(io_cur_log2), 0);
    chk("rst_tick", 32'(io_tick), 0);
    chk("rst_busy", 32'(io_busy), 0);
    chk("rst_level", 32'(io_clk_level), 0);
    reset = 0;
    step();
    chk("post_rst_ready", 32'(io_req_ready), 1);

    // k=2 from IDLE, then enable: ticks at 3,7,11, level 0,0,1,1
    io_req_valid = 1; io_req_log2 = 2;
    step();
    chk("idle_cur", 32'(io_cur_log2), 2);
    io_req_valid = 0; io_enable = 1;
    step();
    for (int i = 0; i < 12; i++) begin
      chk("k2_tick", 32'(io_tick), 32'(i % 4 == 3));
      chk("k2_level", 32'(io_clk_level), 32'(i % 4 >= 2));
      step();
    end

    // Change to k=0 at cnt=1
    step();
    io_req_valid = 1; io_req_log2 = 0;
    step();
    io_req_valid = 0;
    chk("pend_busy0", 32'(io_busy), 1);
    chk("pend_ready", 32'(io_req_ready), 0);
    chk("pend_tick0", 32'(io_tick), 0);
    chk("pend_cur", 32'(io_cur_log2), 2);
    step();
    chk("pend_busy1", 32'(io_busy), 1);
    chk("pend_tick_old", 32'(io_tick), 1);
    step();
    chk("k0_busy", 32'(io_busy), 0);
    chk("k0_cur", 32'(io_cur_log2), 0);
    chk("k0_tick_a", 32'(io_tick), 1);
    step();
    chk("k0_tick_b", 32'(io_tick), 1);
    chk("k0_level", 32'(io_clk_level), 1);

    // Clamp k=15 -> 10, period 1024
    io_req_valid = 1; io_req_log2 = 15;
    step();
    io_req_valid = 0;
    chk("clamp_busy", 32'(io_busy), 1);
    step();
    chk("clamp_cur", 32'(io_cur_log2), ML);
    chk("clamp_busy_off", 32'(io_busy), 0);
    ticks = 0; last = -1;
    for (int i = 0; i < 1024; i++) begin
      if (io_tick) begin ticks++; last = i; end
      step();
    end
    chk("clamp_nticks", 32'(ticks), 1);
    chk("clamp_tick_pos", 32'(last), 1023);

    // Enable drop while PEND (3 -> 1)
    io_enable = 0;
    step();
    io_req_valid = 1; io_req_log2 = 3;
    step();
    io_req_valid = 0; io_enable = 1;
    step();
    step();
    io_req_valid = 1; io_req_log2 = 1;
    step();
    chk("drop_pend_busy", 32'(io_busy), 1);
    io_req_valid = 0; io_enable = 0;
    step();
    chk("drop_cur", 32'(io_cur_log2), 1);
    chk("drop_tick", 32'(io_tick), 0);
    chk("drop_busy", 32'(io_busy), 0);
    chk("drop_ready", 32'(io_req_ready), 1);
    chk("drop_level", 32'(io_clk_level), 0);

    // Reset while PEND discards the pending exponent
    io_enable = 1;
    step();
    io_req_valid = 1; io_req_log2 = 3;
    step();
    chk("rpend_busy", 32'(io_busy), 1);
    io_req_valid = 0; reset = 1;
    step();
    chk("rpend_cur", 32'(io_cur_log2), 0);
    chk("rpend_busy0", 32'(io_busy), 0);
    chk("rpend_ready", 32'(io_req_ready), 0);
    reset = 0; io_enable = 0;
    step();
    chk("rpend_ready1", 32'(io_req_ready), 1);
    io_enable = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("rpend_k0_tick", 32'(io_tick), 1);
      chk("rpend_k0_cur", 32'(io_cur_log2), 0);
      step();
    end

`ifdef POW2_DIV_CTRL_TICK_CNT_EN
    // Tick counter wrap: 65537 ticks at k=0 leaves count 1
    reset = 1; io_enable = 0;
    step();
    reset = 0;
    step();
    io_enable = 1;
    step();
    for (int i = 0; i < 65537; i++) step();
    chk("tcnt_wrap", 32'(io_tick_count), 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      io_enable    = ($urandom_range(0, 9) != 0);
      io_req_valid = ($urandom_range(0, 4) == 0);
      io_req_log2  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                                 : LW'($urandom_range(0, 3));
      step();
    end
    reset = 0; io_enable = 0; io_req_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pow2_div_ctrl.md
POW2_DIV_CTRL -- requirements
Module: pow2_div_ctrl

Interface
REQ-001 SHALL have parameter LOG2_W, default 4: width of divide-exponent fields.
REQ-002 SHALL have parameter MAX_LOG2, default 15: largest legal exponent; MAX_LOG2 <= 2^LOG2_W-1.
REQ-003 SHALL have port clock  input  1: sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port io_enable  input  1: run (1) / stop (0) the divider.
REQ-006 SHALL have port io_req_valid  input  1: exponent-change request.
REQ-007 SHALL have port io_req_ready  output  1: request accepted when valid&ready.
REQ-008 SHALL have port io_req_log2  input  LOG2_W: requested exponent k; divide ratio 2^k.
REQ-009 SHALL have port io_tick  output  1: one-cycle pulse at the last cycle of each divided period.
REQ-010 SHALL have port io_clk_level  output  1: divided-clock level, 50% duty for k>=1.
REQ-011 SHALL have port io_cur_log2  output  LOG2_W: exponent currently in effect.
REQ-012 SHALL have port io_busy  output  1: change accepted but not yet applied.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PEND.
REQ-014 Counter cnt SHALL be MAX_LOG2 bits; in RUN/PEND it increments each cycle, wrapping to 0 after reaching 2^cur-1.
REQ-015 io_tick SHALL be 1 iff state in {RUN, PEND} and cnt == 2^cur-1; for cur=0, io_tick is 1 every running cycle.
REQ-016 io_clk_level SHALL equal cnt[cur-1] for cur>=1, 1 for cur=0 while running, 0 in IDLE.
REQ-017 io_req_ready SHALL be 1 in IDLE and RUN, 0 in PEND.
REQ-018 Accepted io_req_log2 > MAX_LOG2 SHALL be clamped to MAX_LOG2.
REQ-019 IDLE: accepted request updates io_cur_log2 next cycle; cnt held 0.
REQ-020 IDLE -> RUN when io_enable=1; first tick at cycle 2^cur-1 after entering RUN.
REQ-021 RUN + accepted request -> PEND, pending exponent latched; io_busy=1.
REQ-022 PEND: on the tick cycle, tick still issued at old ratio; next cycle cur=pending, cnt=0, state RUN, io_busy=0.
REQ-023 Request equal to current exponent SHALL still traverse PEND (uniform latency).
REQ-024 io_enable=0 in RUN or PEND SHALL go IDLE next cycle, clear cnt, suppress io_tick that cycle; any pending exponent is applied immediately.
REQ-025 Request and io_enable fall in the same RUN cycle: request accepted, applied on entry to IDLE.
REQ-026 All outputs SHALL be registered or decoded from registered state only (no input-to-output combinational path except none).

Reset
REQ-027 reset SHALL force state IDLE, cnt=0, io_cur_log2=0, pending=0, io_tick=0, io_clk_level=0, io_busy=0, io_req_ready=0 during reset, 1 the cycle after.
REQ-028 reset mid-PEND SHALL discard the pending exponent.

Configuration
REQ-029 Macro POW2_DIV_CTRL_TICK_CNT_EN defined: adds output io_tick_count [15:0], increments on each io_tick, wraps 0xFFFF->0, cleared only by reset.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 Package pow2_div_ctrl_pkg SHALL hold state enum, TICK_CNT_W=16, and default LOG2_W/MAX_LOG2 constants.
REQ-032 Sub-module pow2_div_counter SHALL hold cnt, wrap and terminal-compare logic; FSM and handshake stay in top.

Verification
REQ-033 reset, req k=2 in IDLE, enable -> io_tick on cycles 3,7,11 after RUN entry; io_clk_level 0,0,1,1 repeating.
REQ-034 Running k=2, req k=0 at cnt=1 -> busy 2 cycles, tick at cnt=3, then tick every cycle, cur_log2=0.
REQ-035 req k=15 with LOG2_W=4, MAX_LOG2=10 -> cur_log2=10, period 1024 cycles.
REQ-036 enable drop in PEND (k 3->1) -> next cycle IDLE, cur_log2=1, tick 0, busy 0, ready 1.
REQ-037 reset asserted in PEND -> cur_log2=0, busy 0, pending discarded after release.
REQ-038 TICK_CNT_EN, k=0, 65537 running cycles -> io_tick_count=1 (wrap).
